// File: rtl/dffnq_pipe_pkg.sv
// Shared definitions for the negative-edge scan pipeline: parameter limits,
// the per-edge mode priority and the valid-count helpers.
package dffnq_pipe_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_FLOW  = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_RESET = 2'd3
  } mode_e;

  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit paramsLegal(input int width, input int depth);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

  // Reset beats scan, scan beats advance, otherwise everything holds.
  function automatic mode_e decodeMode(input logic r, input logic se, input logic e);
    if (r)  return MODE_RESET;
    if (se) return MODE_SCAN;
    if (e)  return MODE_FLOW;
    return MODE_HOLD;
  endfunction

  function automatic logic [4:0] countOnes(input logic [DEPTH_MAX-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < DEPTH_MAX; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/dffnq_pipe_stage.sv
// One pipeline stage: WIDTH-bit falling-edge register with a valid bit,
// synchronous reset, advance enable and a serial scan path through the data bits.
module dffnq_pipe_stage
  import dffnq_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clkn,
  input  mode_e            i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_vin,
  input  logic             i_scanIn,
  output logic [WIDTH-1:0] o_q,
  output logic             o_qv
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [WIDTH-1:0] w_shift;

  if (WIDTH == 1) begin : g_shiftNarrow
    assign w_shift = i_scanIn;
  end else begin : g_shiftWide
    assign w_shift = {r_data[WIDTH-2:0], i_scanIn};
  end

  // Valid bit is deliberately left alone in scan mode; it is not part of the chain.
  always_ff @(negedge i_clkn) begin
    case (i_mode)
      MODE_RESET: begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end
      MODE_SCAN: r_data <= w_shift;
      MODE_FLOW: begin
        r_data  <= i_d;
        r_valid <= i_vin;
      end
      default: ;
    endcase
  end

  assign o_q  = r_data;
  assign o_qv = r_valid;

endmodule

// File: rtl/dffnq_pipe.sv
// DEPTH-stage falling-edge data pipeline with valid tracking, a registered
// valid-stage count, and a scan chain threaded through every data bit.
module dffnq_pipe
  import dffnq_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                         CLKN,
  input  logic                         R,
  input  logic [WIDTH-1:0]             D,
  input  logic                         VIN,
  input  logic                         E,
  input  logic                         SE,
  input  logic                         SI,
  output logic [WIDTH-1:0]             Q,
  output logic                         QV,
  output logic                         SO,
  output logic [cntWidth(DEPTH)-1:0]   CNT
);

  localparam int CW = cntWidth(DEPTH);

  if (!paramsLegal(WIDTH, DEPTH)) begin : g_badParams
    $error("dffnq_pipe: WIDTH must be 1..64 and DEPTH must be 1..16");
  end

  mode_e                w_mode;
  logic [WIDTH-1:0]     w_data [DEPTH];
  logic [WIDTH-1:0]     w_dIn  [DEPTH];
  logic [DEPTH-1:0]     w_sIn;
  logic [DEPTH-1:0]     w_valid;
  logic [DEPTH-1:0]     w_vIn;
  logic [DEPTH-1:0]     w_validNext;
  logic [DEPTH_MAX-1:0] w_validExt;
  logic [CW-1:0]        r_cnt;

  assign w_mode = decodeMode(R, SE, E);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_dIn[k] = D;
      assign w_vIn[k] = VIN;
      assign w_sIn[k] = SI;
    end else begin : g_body
      assign w_dIn[k] = w_data[k-1];
      assign w_vIn[k] = w_valid[k-1];
      assign w_sIn[k] = w_data[k-1][WIDTH-1];
    end

    dffnq_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .i_clkn   (CLKN),
      .i_mode   (w_mode),
      .i_d      (w_dIn[k]),
      .i_vin    (w_vIn[k]),
      .i_scanIn (w_sIn[k]),
      .o_q      (w_data[k]),
      .o_qv     (w_valid[k])
    );
  end

  // Mirror what the stages will hold after this edge so the count lands in step with them.
  always_comb begin
    w_validNext = w_valid;
    w_validExt  = '0;
    case (w_mode)
      MODE_RESET: w_validNext = '0;
      MODE_FLOW:  w_validNext = w_vIn;
      default: ;
    endcase
    w_validExt[DEPTH-1:0] = w_validNext;
  end

  always_ff @(negedge CLKN) begin
    if (R) r_cnt <= '0;
    else   r_cnt <= CW'(countOnes(w_validExt));
  end

  assign Q   = w_data[DEPTH-1];
  assign QV  = w_valid[DEPTH-1];
  assign SO  = w_data[DEPTH-1][WIDTH-1];
  assign CNT = r_cnt;

endmodule
